// File: rtl/iob_cycle.sv
// iob_cycle: I/O-bus cycle sequencer between the chip-select decoder and the slow I/O bus FSM.
// Define IOB_POSTED_WR_EN to acknowledge plain writes early and let the I/O bus finish in the background.
module iob_cycle #(
   parameter int TIMEOUT = 255
) (
   input  logic CLK,
   input  logic nRES,
   input  logic CACT,
   input  logic IOCS,
   input  logic IACS,
   input  logic nWE,
   input  logic IOACK,
   output logic IOREQ,
   output logic IORW,
   output logic IOIACK,
   output logic IOLE,
   output logic nDTACK,
   output logic nBERR,
   output logic IOERR
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LATCH = 3'd1,
      REQ   = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       served, served_nxt;
   logic       posted, posted_nxt;
   logic       abandoned, abandoned_nxt;
   logic       iorw_nxt, ioiack_nxt, ioreq_nxt, iole_nxt, ndtack_nxt, nberr_nxt;
   logic       start, timeout, posted_req, ack_ok, dtack_set, berr_set;

`ifdef IOB_POSTED_WR_EN
   assign posted_req = !nWE && !IACS;
`else
   assign posted_req = 1'b0;
`endif

   assign start   = (state == IDLE) && CACT && IOCS && !served;
   assign timeout = (cnt == CNT_LAST);
   // Acknowledges only go to the CPU cycle that launched the request and is still running.
   assign ack_ok  = CACT && !posted && !abandoned;

   // Next-state, counter and request-context decode.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      posted_nxt    = posted;
      abandoned_nxt = abandoned;
      iorw_nxt      = IORW;
      ioiack_nxt    = IOIACK;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt     = LATCH;
               iorw_nxt      = nWE;
               ioiack_nxt    = IACS;
               posted_nxt    = posted_req;
               abandoned_nxt = 1'b0;
            end else begin
               state_nxt = IDLE;
            end
         end
         LATCH: begin
            state_nxt = REQ;
            cnt_nxt   = 8'd0;
         end
         REQ: begin
            cnt_nxt = cnt + 8'd1;
            if (IOACK) begin
               state_nxt = DONE;
            end else if (timeout) begin
               state_nxt = ERR;
            end else begin
               state_nxt = REQ;
            end
         end
         DONE, ERR: begin
            // Posted or orphaned cycles have nobody to acknowledge, so leave at once.
            if (posted || abandoned || !CACT) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = state;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (!CACT && !posted && ((state == LATCH) || (state == REQ))) begin
         abandoned_nxt = 1'b1;
      end else begin
         abandoned_nxt = abandoned_nxt;
      end
   end

   // Registered strobe and acknowledge values derived from the next state.
   always_comb begin
      ioreq_nxt  = 1'b0;
      iole_nxt   = 1'b0;
      dtack_set  = 1'b0;
      berr_set   = 1'b0;
      ndtack_nxt = 1'b1;
      nberr_nxt  = 1'b1;
      served_nxt = 1'b0;
      ioreq_nxt  = (state_nxt == REQ);
      iole_nxt   = (state_nxt == LATCH);
      if ((state == LATCH) && posted && CACT) begin
         dtack_set = 1'b1;
      end else if ((state == REQ) && IOACK && ack_ok) begin
         dtack_set = 1'b1;
      end else begin
         dtack_set = 1'b0;
      end
      if ((state == REQ) && !IOACK && timeout && ack_ok) begin
         berr_set = 1'b1;
      end else begin
         berr_set = 1'b0;
      end
      // Both acknowledges hold until the CPU ends its AS cycle.
      ndtack_nxt = !(CACT && (!nDTACK || dtack_set));
      nberr_nxt  = !(CACT && (!nBERR || berr_set));
      served_nxt = CACT && (served || !nDTACK || !nBERR);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!nRES) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         served    <= 1'b0;
         posted    <= 1'b0;
         abandoned <= 1'b0;
         IOREQ     <= 1'b0;
         IOLE      <= 1'b0;
         IORW      <= 1'b1;
         IOIACK    <= 1'b0;
         nDTACK    <= 1'b1;
         nBERR     <= 1'b1;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         served    <= served_nxt;
         posted    <= posted_nxt;
         abandoned <= abandoned_nxt;
         IOREQ     <= ioreq_nxt;
         IOLE      <= iole_nxt;
         IORW      <= iorw_nxt;
         IOIACK    <= ioiack_nxt;
         nDTACK    <= ndtack_nxt;
         nBERR     <= nberr_nxt;
      end
   end

`ifdef IOB_POSTED_WR_EN
   // Posted-write timeout flag; only a reset clears it.
   always_ff @(posedge CLK) begin
      if (!nRES) begin
         IOERR <= 1'b0;
      end else if ((state == ERR) && posted) begin
         IOERR <= 1'b1;
      end else begin
         IOERR <= IOERR;
      end
   end
`else
   assign IOERR = 1'b0;
`endif

endmodule
